store_queue_wsel: RTL and testbench

Parametrised, buffered store path between the execute stage and the memory/IO fabric. Accepts store requests (address, rs2 data, funct3) into a DEPTH-entry FIFO, generates byte-lane enables and lane-aligned data for a configurable XLEN, splits word-crossing misaligned stores into two beats, and decodes each beat to one target (dmem, imem, UART, cycle-counter reset). Drains one beat at a time over a valid/ready port, decoupling the pipeline from memory and IO back-pressure.

---
 rtl/store_queue_wsel.sv | 246 ++++++++++++++++++++++++
 tb/tb_store_queue_wsel.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_wsel.sv
// store_queue_wsel
// Buffered store path from execute to the memory/IO fabric. Store requests
// are queued, converted into lane-aligned beats (word-crossing misaligned
// stores become two beats), decoded to a single target and drained one beat
// at a time over a valid/ready port.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready = queue not full)
//   req_addr              byte address of the store
//   req_data              rs2 value
//   req_funct3            SB/SH/SW/SD size code
//   req_pc30              PC[30] of the issuing store (gates imem writes)
//   mem_valid/mem_ready   beat handshake towards the fabric
//   mem_addr              NB-aligned beat address
//   mem_data              lane-aligned data, unused lanes zero
//   mem_be                byte enables
//   mem_tgt               one-hot {counter_reset, uart, imem, dmem}
//   err                   one-cycle pulse when an illegal funct3 is dropped
//   empty                 queue empty and no beat in flight
module store_queue_wsel #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic [XLEN-1:0]     req_data,
    input  logic [2:0]          req_funct3,
    input  logic                req_pc30,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [31:0]         mem_addr,
    output logic [XLEN-1:0]     mem_data,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [3:0]          mem_tgt,
    output logic                err,
    output logic                empty
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned OFS = $clog2(NB);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;

    localparam logic [3:0] TGT_DMEM = 4'b0001;
    localparam logic [3:0] TGT_IMEM = 4'b0010;
    localparam logic [3:0] TGT_UART = 4'b0100;
    localparam logic [3:0] TGT_CNT  = 4'b1000;

    typedef struct packed {
        logic [31:0]     addr;
        logic [XLEN-1:0] data;
        logic [NB-1:0]   be;
        logic [3:0]      tgt;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B0   = 2'd1,
        ST_B1   = 2'd2
    } state_t;

    // Address map decode for one beat; zero means no target.
    function automatic logic [3:0] decode_tgt(input logic [31:0] a, input logic pc30);
        logic [3:0] t;
        t = '0;
        if (a[31] && (a[5:3] == 3'b001))
            t = TGT_UART;
        else if (a[31] && (a[5:3] == 3'b011))
            t = TGT_CNT;
        else if (a[29] && pc30)
            t = TGT_IMEM;
        else if (a[28])
            t = TGT_DMEM;
        return t;
    endfunction

    // Build beat0 (hi=0) or beat1 (hi=1) of a queued store.
    // Enables and data are formed in a double-width window and then split.
    function automatic beat_t entry_beat(
        input logic [31:0]     addr,
        input logic [XLEN-1:0] data,
        input logic [1:0]      size,
        input logic            pc30,
        input logic            hi
    );
        logic [NB-1:0]     lane_m;
        logic [XLEN-1:0]   data_m;
        logic [2*NB-1:0]   be2;
        logic [2*XLEN-1:0] data2;
        logic [OFS-1:0]    o;
        beat_t             b;
        o = addr[OFS-1:0];
        for (int unsigned i = 0; i < NB; i++) begin
            lane_m[i]        = (i < (32'd1 << size));
            data_m[8*i +: 8] = lane_m[i] ? data[8*i +: 8] : 8'h00;
        end
        be2    = {{NB{1'b0}}, lane_m} << o;
        data2  = {{XLEN{1'b0}}, data_m} << {o, 3'b000};
        b.addr = {addr[31:OFS], {OFS{1'b0}}} + (hi ? 32'(NB) : 32'd0);
        b.be   = hi ? be2[2*NB-1:NB] : be2[NB-1:0];
        b.data = hi ? data2[2*XLEN-1:XLEN] : data2[XLEN-1:0];
        b.tgt  = decode_tgt(b.addr, pc30);
        // The UART only takes lane 0.
        if (b.tgt == TGT_UART)
            b.be = {{(NB-1){1'b0}}, b.be[0]};
        // Unmapped beats are dropped; keep the payload clean.
        if (b.tgt == 4'b0000)
            b = '0;
        return b;
    endfunction

    // A store crosses into a second beat when offset + size exceeds a word.
    function automatic logic entry_cross(input logic [31:0] addr, input logic [1:0] size);
        return (32'(addr[OFS-1:0]) + (32'd1 << size)) > 32'(NB);
    endfunction

    // Queue storage
    logic [31:0]     q_addr [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [1:0]      q_size [DEPTH];
    logic            q_pc30 [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_p1;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    state_t state;
    beat_t  out_beat;

    logic  req_fire;
    logic  req_legal;
    logic  enq;
    logic  beat_done;
    logic  pop;
    logic  head_cross;
    beat_t head_b0;
    beat_t head_b1;
    beat_t next_b0;
    beat_t load_beat;

    // Request acceptance; illegal sizes are consumed but never stored.
    always_comb begin
        req_fire  = req_valid && req_ready;
        req_legal = !req_funct3[2] && !((XLEN == 32) && (req_funct3[1:0] == 2'b11));
        enq       = req_fire && req_legal;
    end

    // Beats of the head entry and beat0 of the entry behind it.
    always_comb begin
        rd_ptr_p1  = rd_ptr + PW'(1);
        head_b0    = entry_beat(q_addr[rd_ptr], q_data[rd_ptr], q_size[rd_ptr], q_pc30[rd_ptr], 1'b0);
        head_b1    = entry_beat(q_addr[rd_ptr], q_data[rd_ptr], q_size[rd_ptr], q_pc30[rd_ptr], 1'b1);
        head_cross = entry_cross(q_addr[rd_ptr], q_size[rd_ptr]);
        next_b0    = entry_beat(q_addr[rd_ptr_p1], q_data[rd_ptr_p1], q_size[rd_ptr_p1],
                                q_pc30[rd_ptr_p1], 1'b0);
    end

    // A presented beat finishes on handshake; a discarded one (mem_valid low
    // while in B0/B1) finishes in its single cycle.
    always_comb begin
        beat_done = !mem_valid || mem_ready;
        pop       = (state != ST_IDLE) && beat_done && !((state == ST_B0) && head_cross);
        count_nxt = count + CW'(enq) - CW'(pop);
    end

    // Beat to register when the FSM advances; loaded at the same edge as the
    // handshake so a held-ready fabric sees one beat per cycle.
    always_comb begin
        if (state == ST_IDLE)
            load_beat = head_b0;
        else if ((state == ST_B0) && head_cross)
            load_beat = head_b1;
        else if (count > CW'(1))
            load_beat = next_b0;
        else
            load_beat = '0;
    end

    // Entry write port
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= req_addr;
            q_data[wr_ptr] <= req_data;
            q_size[wr_ptr] <= req_funct3[1:0];
            q_pc30[wr_ptr] <= req_pc30;
        end
    end

    // Pointers, status flags and the drain FSM with its registered beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
            empty     <= 1'b1;
            err       <= 1'b0;
            mem_valid <= 1'b0;
            out_beat  <= '0;
        end else begin
            err       <= req_fire && !req_legal;
            count     <= count_nxt;
            req_ready <= (count_nxt != CW'(DEPTH));
            empty     <= (count_nxt == '0);
            if (enq)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            unique case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state     <= ST_B0;
                        mem_valid <= |load_beat.tgt;
                        out_beat  <= load_beat;
                    end
                end
                default: begin
                    if (beat_done) begin
                        if ((state == ST_B0) && head_cross)
                            state <= ST_B1;
                        else if (count > CW'(1))
                            state <= ST_B0;
                        else
                            state <= ST_IDLE;
                        mem_valid <= |load_beat.tgt;
                        out_beat  <= load_beat;
                    end
                end
            endcase
        end
    end

    assign mem_addr = out_beat.addr;
    assign mem_data = out_beat.data;
    assign mem_be   = out_beat.be;
    assign mem_tgt  = out_beat.tgt;

endmodule

// File: tb/tb_store_queue_wsel.sv
// Testbench for store_queue_wsel (XLEN=32, DEPTH=4): directed cases for the
// address map, lane math and flow control, then randomized traffic checked
// against a byte-level reference model.
module tb_store_queue_wsel;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NB    = XLEN / 8;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic [XLEN-1:0] req_data;
    logic [2:0]      req_funct3;
    logic            req_pc30;
    logic            mem_valid;
    logic            mem_ready;
    logic [31:0]     mem_addr;
    logic [XLEN-1:0] mem_data;
    logic [NB-1:0]   mem_be;
    logic [3:0]      mem_tgt;
    logic            err;
    logic            empty;

    store_queue_wsel #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_funct3 (req_funct3),
        .req_pc30   (req_pc30),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_be     (mem_be),
        .mem_tgt    (mem_tgt),
        .err        (err),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [3:0]  tgt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        err_pending = 1'b0;
    logic        prev_stall = 1'b0;
    logic [95:0] prev_out = '0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Address map taken straight from the target rules.
    function automatic logic [3:0] model_tgt(input logic [31:0] a, input logic p);
        if (a[31] && a[5:3] == 3'b001) return 4'b0100;
        if (a[31] && a[5:3] == 3'b011) return 4'b1000;
        if (a[29] && p)                return 4'b0010;
        if (a[28])                     return 4'b0001;
        return 4'b0000;
    endfunction

    // Place each store byte at its own address, then group by word.
    function automatic void model_push(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] sz, input logic p);
        exp_t        bt [2];
        int unsigned n, off, idx, lane;
        logic [31:0] base;
        n    = 32'd1 << sz;
        base = a - (a % NB);
        for (int i = 0; i < 2; i++) begin
            bt[i]      = '0;
            bt[i].addr = base + 32'(i * int'(NB));
        end
        for (int unsigned k = 0; k < n; k++) begin
            off  = (a % NB) + k;
            idx  = off / NB;
            lane = off % NB;
            bt[idx].be[lane]          = 1'b1;
            bt[idx].data[8*lane +: 8] = d[8*k +: 8];
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0 || bt[i].be != 4'b0000) begin
                bt[i].tgt = model_tgt(bt[i].addr, p);
                if (bt[i].tgt == 4'b0100) bt[i].be = bt[i].be & 4'b0001;
                if (bt[i].tgt != 4'b0000) exp_q.push_back(bt[i]);
            end
        end
    endfunction

    // Scoreboard, err tracking and hold-stability, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall  = 1'b0;
            err_pending = 1'b0;
        end else begin
            chk("err", 96'(err), 96'(err_pending));
            if (prev_stall)
                chk("hold", 96'({mem_valid, mem_addr, mem_data, mem_be, mem_tgt}), prev_out);
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 96'(1), 96'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_addr", 96'(mem_addr), 96'(e.addr));
                    chk("sb_data", 96'(mem_data), 96'(e.data));
                    chk("sb_be",   96'(mem_be),   96'(e.be));
                    chk("sb_tgt",  96'(mem_tgt),  96'(e.tgt));
                end
            end
            prev_stall  = mem_valid && !mem_ready;
            prev_out    = 96'({mem_valid, mem_addr, mem_data, mem_be, mem_tgt});
            err_pending = 1'b0;
            if (req_valid && req_ready) begin
                if (!req_funct3[2] && req_funct3[1:0] != 2'b11)
                    model_push(req_addr, req_data, req_funct3[1:0], req_pc30);
                else
                    err_pending = 1'b1;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input logic p);
        bit done;
        done       = 0;
        req_valid  = 1'b1;
        req_addr   = a;
        req_data   = d;
        req_funct3 = f;
        req_pc30   = p;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (req_ready) done = 1;
        end
        if (!done) chk("send_timeout", 96'(0), 96'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic [3:0] tgt);
        bit seen;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (mem_valid) seen = 1;
        end
        chk({tag, "_seen"}, 96'(seen), 96'(1));
        if (seen) begin
            chk({tag, "_addr"}, 96'(mem_addr), 96'(a));
            chk({tag, "_data"}, 96'(mem_data), 96'(d));
            chk({tag, "_be"},   96'(mem_be),   96'(be));
            chk({tag, "_tgt"},  96'(mem_tgt),  96'(tgt));
        end
        @(posedge clk); #1;
    endtask

    task automatic expect_none(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            if (mem_valid) seen++;
        end
        chk(tag, 96'(seen), 96'(0));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (empty) done = 1;
        end
        chk({tag, "_empty"}, 96'(done), 96'(1));
        chk({tag, "_model"}, 96'(exp_q.size()), 96'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_funct3 = '0;
        req_pc30   = 1'b0;
        mem_ready  = 1'b0;

        #12;
        chk("rst_mem_valid", 96'(mem_valid), 96'(0));
        chk("rst_mem_addr",  96'(mem_addr),  96'(0));
        chk("rst_mem_data",  96'(mem_data),  96'(0));
        chk("rst_mem_be",    96'(mem_be),    96'(0));
        chk("rst_mem_tgt",   96'(mem_tgt),   96'(0));
        chk("rst_err",       96'(err),       96'(0));
        chk("rst_empty",     96'(empty),     96'(1));
        chk("rst_req_ready", 96'(req_ready), 96'(1));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        mem_ready = 1'b1;
        send(32'h1000_0003, 32'hAABB_CCDD, 3'b000, 1'b0);
        expect_beat("sb_misal", 32'h1000_0000, 32'hDD00_0000, 4'b1000, 4'b0001);
        drain("d1");

        send(32'h1000_0006, 32'h1122_3344, 3'b010, 1'b0);
        expect_beat("sw_b0", 32'h1000_0004, 32'h3344_0000, 4'b1100, 4'b0001);
        expect_beat("sw_b1", 32'h1000_0008, 32'h0000_1122, 4'b0011, 4'b0001);
        drain("d2");

        send(32'h2000_0000, 32'hCAFE_F00D, 3'b010, 1'b0);
        expect_none("imem_blocked", 8);
        drain("d3");
        send(32'h2000_0000, 32'hCAFE_F00D, 3'b010, 1'b1);
        expect_beat("imem_ok", 32'h2000_0000, 32'hCAFE_F00D, 4'b1111, 4'b0010);
        drain("d4");

        send(32'h8000_0008, 32'h0000_0041, 3'b000, 1'b0);
        expect_beat("uart", 32'h8000_0008, 32'h0000_0041, 4'b0001, 4'b0100);
        send(32'h8000_0018, 32'hDEAD_BEEF, 3'b010, 1'b0);
        expect_beat("cnt_rst", 32'h8000_0018, 32'hDEAD_BEEF, 4'b1111, 4'b1000);
        drain("d5");

        // Fill under back-pressure, then release and expect a solid burst.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(32'h1000_0100 + 32'(4 * i), 32'h5000_0000 + 32'(i), 3'b010, 1'b0);
        @(negedge clk);
        chk("full_req_ready", 96'(req_ready), 96'(0));
        chk("full_empty",     96'(empty),     96'(0));
        chk("full_mem_valid", 96'(mem_valid), 96'(1));
        @(posedge clk); #1;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("burst_%0d", i), 96'(mem_valid), 96'(1));
        end
        @(negedge clk);
        chk("burst_empty", 96'(empty), 96'(1));
        @(posedge clk); #1;

        send(32'h1000_0000, 32'h1234_5678, 3'b011, 1'b0);
        chk("err_pulse", 96'(err), 96'(1));
        @(posedge clk); #1;
        chk("err_clear", 96'(err), 96'(0));
        expect_none("err_no_beat", 6);

        // Asynchronous reset with two entries queued.
        mem_ready = 1'b0;
        send(32'h1000_0200, 32'h0000_0001, 3'b010, 1'b0);
        send(32'h1000_0204, 32'h0000_0002, 3'b010, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 96'(mem_valid), 96'(1));
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", 96'(mem_valid), 96'(0));
        chk("async_rst_empty", 96'(empty),     96'(1));
        chk("async_rst_ready", 96'(req_ready), 96'(1));
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_none("post_rst_quiet", 4);

        // Randomized traffic
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int unsigned r;
            req_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 4))
                0: req_addr = 32'h1000_0000 | 32'($urandom_range(0, 255));
                1: req_addr = 32'h2000_0000 | 32'($urandom_range(0, 255));
                2: req_addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
                3: req_addr = 32'h0000_1000 | 32'($urandom_range(0, 255));
                default: req_addr = 32'h3000_0000 | 32'($urandom_range(0, 255));
            endcase
            req_data   = $urandom;
            r          = $urandom_range(0, 7);
            req_funct3 = (r < 6) ? 3'(r % 3) : 3'(3 + $urandom_range(0, 4));
            req_pc30   = ($urandom_range(0, 1) == 1);
            mem_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        mem_ready = 1'b1;
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
